nlynx_tcdm_responder: RTL and testbench

NLYNX_TCDM_RESPONDER -- requirements
Module: nlynx_tcdm_responder

---
 rtl/nlynx_resp_pkg.sv | 23 ++
 rtl/nlynx_snap_fifo.sv | 48 ++++
 rtl/nlynx_tcdm_responder.sv | 114 +++++++++++
 tb/tb_nlynx_tcdm_responder.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/nlynx_resp_pkg.sv
// nlynx_resp_pkg: word offsets, STATUS fields and snapshot entry type shared by the responder and its FIFO.
// NLYNX_RESP_TIMESTAMP_EN adds a timestamp field to each entry and the timestamp word offset.
package nlynx_resp_pkg;
  localparam int MAX_METRICS  = 32;
  localparam int OFS_MASK     = 0;
  localparam int OFS_STATUS   = 1;
`ifdef NLYNX_RESP_TIMESTAMP_EN
  localparam int OFS_TS       = 2;
`endif
  localparam int ST_LEVEL_LSB = 0;
  localparam int ST_LEVEL_W   = 4;
  localparam int ST_DROP_LSB  = 8;
  localparam int ST_DROP_W    = 8;
  localparam int CTL_POP      = 0;
  localparam int CTL_CLR      = 1;
  typedef struct packed {
`ifdef NLYNX_RESP_TIMESTAMP_EN
    logic [31:0]                  ts;
`endif
    logic [MAX_METRICS-1:0]       ovf;
    logic [MAX_METRICS-1:0][31:0] cnt;
  } nlynx_snap_t;
endpackage

// File: rtl/nlynx_snap_fifo.sv
// nlynx_snap_fifo: power-of-two snapshot FIFO; a pop frees a slot for a push in the same cycle when full.
module nlynx_snap_fifo
  import nlynx_resp_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        push_i,
  input  logic        pop_i,
  input  nlynx_snap_t data_i,
  output logic        full_o,
  output logic        empty_o,
  output logic [3:0]  level_o,
  output nlynx_snap_t head_o
);
  localparam int PW = $clog2(DEPTH);
  nlynx_snap_t mem_q [DEPTH];
  logic [PW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [3:0] level_q, level_d;
  logic do_push, do_pop;
  // Next pointers and level; pops on empty are ignored, pushes on full only succeed with a pop
  always_comb begin
    empty_o = level_q == 4'd0;
    full_o  = level_q == 4'(DEPTH);
    do_pop  = pop_i & ~empty_o;
    do_push = push_i & (~full_o | do_pop);
    wptr_d  = wptr_q + PW'(do_push);
    rptr_d  = rptr_q + PW'(do_pop);
    level_d = level_q + {3'b0, do_push} - {3'b0, do_pop};
    level_o = level_q;
    head_o  = mem_q[rptr_q];
  end
  // Pointer and level registers
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      level_q <= level_d;
    end
  // Entry storage; contents are only meaningful below the level so no reset is needed
  always_ff @(posedge clk_i)
    if (do_push) mem_q[wptr_q] <= data_i;
endmodule

// File: rtl/nlynx_tcdm_responder.sv
// nlynx_tcdm_responder: TCDM slave exposing metric snapshots through a FIFO with one-cycle registered responses.
// NLYNX_RESP_TIMESTAMP_EN enables a free-running cycle stamp per snapshot, readable at word N+2.
module nlynx_tcdm_responder
  import nlynx_resp_pkg::*;
#(
  parameter int NLYNX_METRICS       = 13,
  parameter int NLYNX_COUNTER_WIDTH = 32,
  parameter int SNAP_DEPTH          = 2
) (
  input  logic                                         clk_i,
  input  logic                                         rst_ni,
  input  logic [NLYNX_METRICS*NLYNX_COUNTER_WIDTH-1:0] nlynx_counters_i,
  input  logic [NLYNX_METRICS-1:0]                     nlynx_overflow_i,
  input  logic                                         nlynx_eop_i,
  input  logic                                         req_i,
  input  logic [31:0]                                  add_i,
  input  logic                                         wen_i,
  input  logic [31:0]                                  wdata_i,
  input  logic [3:0]                                   be_i,
  output logic                                         gnt_o,
  output logic                                         r_valid_o,
  output logic [31:0]                                  r_rdata_o,
  output logic                                         r_opc_o
);
  localparam logic [9:0] W_CNT_END = 10'(NLYNX_METRICS);
  localparam logic [9:0] W_MASK    = 10'(NLYNX_METRICS + OFS_MASK);
  localparam logic [9:0] W_STATUS  = 10'(NLYNX_METRICS + OFS_STATUS);
`ifdef NLYNX_RESP_TIMESTAMP_EN
  localparam logic [9:0] W_TS      = 10'(NLYNX_METRICS + OFS_TS);
`endif
  nlynx_snap_t entry, head;
  logic [9:0] widx;
  logic is_cnt, is_mask, is_stat, is_ts, rd, err, pop, clr, drop, full, empty;
  logic [3:0] level;
  logic [31:0] status, ts_word;
  logic [7:0] drop_q, drop_d;
  logic r_valid_q, r_valid_d, r_opc_q, r_opc_d;
  logic [31:0] r_rdata_q, r_rdata_d;
  logic unused_ok;
`ifdef NLYNX_RESP_TIMESTAMP_EN
  logic [31:0] ts_q, ts_d;
  assign ts_word = head.ts;
  assign is_ts   = widx == W_TS;
  assign ts_d    = ts_q + 32'd1;
  // Free-running cycle counter stamped into each pushed snapshot
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) ts_q <= '0;
    else ts_q <= ts_d;
`else
  assign ts_word = '0;
  assign is_ts   = 1'b0;
`endif
  assign unused_ok = ^{be_i, wdata_i[31:2], add_i[31:12], add_i[1:0]};
  assign gnt_o     = req_i;
  assign r_valid_o = r_valid_q;
  assign r_rdata_o = r_rdata_q;
  assign r_opc_o   = r_opc_q;
  // Pack live counters into a zero-extended snapshot entry
  always_comb begin
    entry     = '0;
    entry.ovf = MAX_METRICS'(nlynx_overflow_i);
    for (int i = 0; i < NLYNX_METRICS; i++)
      entry.cnt[i] = 32'(nlynx_counters_i[i*NLYNX_COUNTER_WIDTH +: NLYNX_COUNTER_WIDTH]);
`ifdef NLYNX_RESP_TIMESTAMP_EN
    entry.ts = ts_q;
`endif
  end
  nlynx_snap_fifo #(.DEPTH(SNAP_DEPTH)) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (nlynx_eop_i),
    .pop_i   (pop),
    .data_i  (entry),
    .full_o  (full),
    .empty_o (empty),
    .level_o (level),
    .head_o  (head)
  );
  // Decode, error classification and response data, all from pre-update FIFO state
  always_comb begin
    widx    = add_i[11:2];
    is_cnt  = widx < W_CNT_END;
    is_mask = widx == W_MASK;
    is_stat = widx == W_STATUS;
    status  = '0;
    status[ST_LEVEL_LSB +: ST_LEVEL_W] = level;
    status[ST_DROP_LSB +: ST_DROP_W]   = drop_q;
    rd      = req_i & wen_i;
    err     = req_i & (~(is_cnt | is_mask | is_stat | is_ts) | (~wen_i & ~is_stat) | (wen_i & empty & ~is_stat));
    pop     = req_i & ~wen_i & is_stat & wdata_i[CTL_POP];
    clr     = req_i & ~wen_i & is_stat & wdata_i[CTL_CLR];
    drop    = nlynx_eop_i & full & ~pop;
    drop_d  = clr ? 8'd0 : (drop && drop_q != 8'hFF) ? drop_q + 8'd1 : drop_q;
    r_valid_d = req_i;
    r_opc_d   = err;
    r_rdata_d = (!rd || err) ? 32'd0 :
                is_cnt       ? head.cnt[widx[4:0]] :
                is_mask      ? head.ovf :
                is_stat      ? status : ts_word;
  end
  // Dropped-snapshot count and response register
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      drop_q    <= '0;
      r_valid_q <= 1'b0;
      r_rdata_q <= '0;
      r_opc_q   <= 1'b0;
    end else begin
      drop_q    <= drop_d;
      r_valid_q <= r_valid_d;
      r_rdata_q <= r_rdata_d;
      r_opc_q   <= r_opc_d;
    end
endmodule

// File: tb/tb_nlynx_tcdm_responder.sv
// tb_nlynx_tcdm_responder: directed scoreboard bench for the snapshot responder.
module tb_nlynx_tcdm_responder;
  localparam int N = 13;
  localparam int CW = 32;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  logic [N*CW-1:0] cnt;
  logic [N-1:0] ovf;
  logic eop = 1'b0, req = 1'b0, wen = 1'b1;
  logic [31:0] add = '0, wdata = '0;
  logic [3:0] be = '0;
  logic gnt, r_valid, r_opc;
  logic [31:0] r_rdata;
  typedef struct {
    logic [31:0] d;
    logic        o;
    string       nm;
  } exp_t;
  exp_t exp_q[$];
  int checks = 0;
  int failures = 0;

  nlynx_tcdm_responder #(.NLYNX_METRICS(N), .NLYNX_COUNTER_WIDTH(CW), .SNAP_DEPTH(2)) dut (
    .clk_i            (clk),
    .rst_ni           (rst_n),
    .nlynx_counters_i (cnt),
    .nlynx_overflow_i (ovf),
    .nlynx_eop_i      (eop),
    .req_i            (req),
    .add_i            (add),
    .wen_i            (wen),
    .wdata_i          (wdata),
    .be_i             (be),
    .gnt_o            (gnt),
    .r_valid_o        (r_valid),
    .r_rdata_o        (r_rdata),
    .r_opc_o          (r_opc)
  );

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%h want=%h", nm, got, want);
    end
  endtask

  task automatic set_cnt(input logic [31:0] mul, input logic [31:0] add0, input logic [N-1:0] o);
    for (int i = 0; i < N; i++) cnt[i*CW +: CW] = mul * 32'(i) + add0;
    ovf = o;
  endtask

  task automatic acc(input logic [9:0] w, input logic rd, input logic [31:0] wd,
                     input logic [31:0] ed, input logic eo, input string nm, input logic ep = 1'b0);
    exp_t e;
    req = 1'b1; wen = rd; add = {20'hABCDE, w, 2'b01}; wdata = wd; be = 4'hA; eop = ep;
    e.d = ed; e.o = eo; e.nm = nm;
    exp_q.push_back(e);
    #1 chk({nm, "_gnt"}, 32'(gnt), 32'd1);
    @(negedge clk);
    req = 1'b0; eop = 1'b0; wdata = '0; add = 32'hFFFF_F000;
  endtask

  task automatic pulse();
    eop = 1'b1;
    @(negedge clk);
    eop = 1'b0;
  endtask

  always @(posedge clk) begin
    #1;
    if (rst_n) begin
      if (exp_q.size() == 0) begin
        if (r_valid) begin
          checks++;
          failures++;
          $display("FAIL spurious_rvalid got r_valid=1 want 0");
        end
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        checks++;
        if (r_valid !== 1'b1 || r_rdata !== e.d || r_opc !== e.o) begin
          failures++;
          $display("FAIL %s got valid=%b rdata=%h opc=%b want valid=1 rdata=%h opc=%b",
                   e.nm, r_valid, r_rdata, r_opc, e.d, e.o);
        end
      end
    end
  end

  initial begin
    set_cnt(0, 0, '0);
    repeat (2) @(negedge clk);
    chk("rst_rvalid", 32'(r_valid), 0);
    chk("rst_rdata", r_rdata, 0);
    chk("rst_opc", 32'(r_opc), 0);
    chk("idle_gnt", 32'(gnt), 0);
    rst_n = 1'b1;
    @(negedge clk);
    acc(14, 1, 0, 32'h0, 0, "status_after_reset");
    set_cnt(3, 0, 13'h0001);
    pulse();
    acc(4, 1, 0, 12, 0, "head_cnt4");
    acc(0, 1, 0, 0, 0, "head_cnt0");
    acc(12, 1, 0, 36, 0, "head_cnt12");
    acc(13, 1, 0, 32'h1, 0, "head_mask");
    acc(14, 1, 0, 32'h1, 0, "status_lvl1");
    set_cnt(5, 1, 13'h1555);
    acc(14, 1, 0, 32'h1, 0, "status_pre_push", 1'b1);
    acc(14, 1, 0, 32'h2, 0, "status_lvl2");
    set_cnt(1, 100, 13'h0AAA);
    pulse();
    acc(14, 1, 0, 32'h0102, 0, "status_drop1");
    acc(4, 1, 0, 12, 0, "head_after_drop");
    set_cnt(1, 32'hA000_0000, 13'h1FFF);
    acc(14, 0, 32'h1, 0, 0, "pop_push_full", 1'b1);
    acc(14, 1, 0, 32'h0102, 0, "status_pop_push_full");
    acc(4, 1, 0, 21, 0, "head2_cnt4");
    acc(13, 1, 0, 32'h1555, 0, "head2_mask");
    acc(14, 0, 32'h2, 0, 0, "clear_drop");
    acc(14, 1, 0, 32'h0002, 0, "status_cleared");
    acc(10'h3FF, 0, 32'h1, 0, 1, "oor_write_pop");
    acc(13, 0, 32'h1, 0, 1, "write_mask_ro");
    acc(14, 1, 0, 32'h0002, 0, "status_no_change");
    acc(14, 0, 32'h1, 0, 0, "pop1");
    acc(4, 1, 0, 32'hA000_0004, 0, "head3_cnt4");
    acc(13, 1, 0, 32'h1FFF, 0, "head3_mask");
    acc(14, 1, 0, 32'h0001, 0, "status_lvl1b");
    acc(14, 0, 32'h1, 0, 0, "pop2");
    acc(14, 1, 0, 32'h0, 0, "status_empty");
    acc(14, 0, 32'h1, 0, 0, "pop_empty");
    acc(14, 1, 0, 32'h0, 0, "status_still_empty");
    acc(0, 1, 0, 0, 1, "rd_cnt_empty");
    acc(13, 1, 0, 0, 1, "rd_mask_empty");
    acc(10'h3FF, 1, 0, 0, 1, "rd_oor");
    acc(0, 0, 32'h5, 0, 1, "wr_cnt0");
    acc(15, 1, 0, 0, 1, "rd_ts_empty");
    pulse();
    pulse();
    eop = 1'b1;
    repeat (260) @(negedge clk);
    eop = 1'b0;
    acc(14, 1, 0, 32'hFF02, 0, "status_drop_sat");
    acc(14, 0, 32'h2, 0, 0, "clear_sat");
    acc(14, 1, 0, 32'h0002, 0, "status_after_clear");
    acc(14, 0, 32'h3, 0, 0, "pop_and_clear");
    acc(14, 1, 0, 32'h0001, 0, "status_pop_clear");
`ifndef NLYNX_RESP_TIMESTAMP_EN
    acc(15, 1, 0, 0, 1, "rd_ts_disabled");
`endif
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("rst2_rvalid", 32'(r_valid), 0);
    chk("rst2_rdata", r_rdata, 0);
    rst_n = 1'b1;
`ifdef NLYNX_RESP_TIMESTAMP_EN
    repeat (100) @(posedge clk);
    @(negedge clk);
    pulse();
    acc(15, 1, 0, 32'd100, 0, "head_ts");
    acc(14, 1, 0, 32'h0001, 0, "status_ts_lvl");
`else
    @(negedge clk);
    acc(14, 1, 0, 32'h0, 0, "status_after_rst2");
`endif
    @(negedge clk);
    @(negedge clk);
    chk("scoreboard_drained", 32'(exp_q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
